// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: scoreboard-driven forwarding, stall, bubble and flush control
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int MEM_LAT = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W = 16,
  localparam int NSLOT = MEM_LAT + 2,
  localparam int FWD_W = $clog2(NSLOT)
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic dec_rs1_used,
  input  logic dec_rs2_used,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic dec_wre,
  input  logic dec_is_load,
  input  logic dec_is_branch,
  input  logic branch_taken,
  output logic stall,
  output logic bubble,
  output logic flush_fd,
  output logic [FWD_W-1:0] fwd_ex_a,
  output logic [FWD_W-1:0] fwd_ex_b,
  output logic [FWD_W-1:0] fwd_dec_a,
  output logic [FWD_W-1:0] fwd_dec_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [NSLOT-1:0] LU_MASK = {NSLOT{1'b1}} >> 2;
  localparam logic [NSLOT-1:0] BR_MASK = {NSLOT{1'b1}} >> 1;
  logic [NSLOT-1:0] sv, sw, sl;
  logic [NSLOT-1:0][REG_ADDR_W-1:0] srd;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;
  logic ex_u1, ex_u2;
  logic [NSLOT-1:0] ha, hb, hea, heb;
  logic lu_stall, br_stall, take;

  function automatic logic [NSLOT-1:0] hit(input logic [REG_ADDR_W-1:0] r);
    logic [NSLOT-1:0] h;
    for (int k = 0; k < NSLOT; k++)
      h[k] = sv[k] & sw[k] & (srd[k] == r) & !(ZERO_REG_EN != 0 && r == '0);
    return h;
  endfunction

  // youngest writer wins; a load still short of writeback yields no forward
  function automatic logic [FWD_W-1:0] pick(input logic [NSLOT-1:0] m, input logic [NSLOT-1:0] ld);
    logic [FWD_W-1:0] s;
    s = '0;
    for (int k = NSLOT - 1; k >= 1; k--)
      if (m[k]) s = (ld[k] && k != NSLOT - 1) ? '0 : FWD_W'(k);
    return s;
  endfunction

  assign ha = hit(dec_rs1) & {NSLOT{dec_rs1_used}};
  assign hb = hit(dec_rs2) & {NSLOT{dec_rs2_used}};
  assign hea = hit(ex_rs1) & {NSLOT{sv[0] & ex_u1}};
  assign heb = hit(ex_rs2) & {NSLOT{sv[0] & ex_u2}};
  assign lu_stall = dec_valid & |((ha | hb) & sl & LU_MASK);
  assign br_stall = dec_valid & dec_is_branch & (ha[0] | hb[0] | |((ha | hb) & sl & BR_MASK));
  assign stall = hold | lu_stall | br_stall;
  assign bubble = stall & !hold;
  assign flush_fd = dec_valid & dec_is_branch & branch_taken & !stall;
  assign take = dec_valid & !stall;
  assign fwd_ex_a = pick(hea, sl);
  assign fwd_ex_b = pick(heb, sl);
  assign fwd_dec_a = dec_is_branch ? pick(ha, sl) : '0;
  assign fwd_dec_b = dec_is_branch ? pick(hb, sl) : '0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sv <= '0;
      sw <= '0;
      sl <= '0;
      srd <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_u1 <= 1'b0;
      ex_u2 <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!hold) begin
      sv <= {sv[NSLOT-2:0], take};
      sw <= {sw[NSLOT-2:0], dec_wre};
      sl <= {sl[NSLOT-2:0], dec_is_load};
      srd <= {srd[NSLOT-2:0], dec_rd};
      ex_rs1 <= dec_rs1;
      ex_rs2 <= dec_rs2;
      ex_u1 <= dec_rs1_used;
      ex_u2 <= dec_rs2_used;
      if (bubble && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (flush_fd && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed and random checks of two configurations against an instruction-level model
module tb_pipeline_hazard_unit;
  logic clk = 0, reset, hold;
  logic dec_valid, dec_rs1_used, dec_rs2_used, dec_wre, dec_is_load, dec_is_branch, branch_taken;
  logic [3:0] dec_rs1, dec_rs2, dec_rd;
  logic s1, b1, f1, s3, b3, f3;
  logic [1:0] ea1, eb1, da1, db1;
  logic [2:0] ea3, eb3, da3, db3;
  logic [15:0] sc1, fc1;
  logic [2:0] sc3, fc3;
  int vectors = 0, miscompares = 0;
  logic [15:0] sav_s, sav_f;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.MEM_LAT(1)) d1 (
    .clk(clk), .reset(reset), .hold(hold), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd), .dec_wre(dec_wre),
    .dec_is_load(dec_is_load), .dec_is_branch(dec_is_branch), .branch_taken(branch_taken),
    .stall(s1), .bubble(b1), .flush_fd(f1), .fwd_ex_a(ea1), .fwd_ex_b(eb1), .fwd_dec_a(da1),
    .fwd_dec_b(db1), .stall_count(sc1), .flush_count(fc1));

  pipeline_hazard_unit #(.MEM_LAT(3), .CNT_W(3)) d3 (
    .clk(clk), .reset(reset), .hold(hold), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd), .dec_wre(dec_wre),
    .dec_is_load(dec_is_load), .dec_is_branch(dec_is_branch), .branch_taken(branch_taken),
    .stall(s3), .bubble(b3), .flush_fd(f3), .fwd_ex_a(ea3), .fwd_ex_b(eb3), .fwd_dec_a(da3),
    .fwd_dec_b(db3), .stall_count(sc3), .flush_count(fc3));

  typedef struct {bit v, w, l, u1, u2; int rd, rs1, rs2;} ins_t;
  ins_t p [2][8];
  int ns [2] = '{3, 5};
  int cmax [2] = '{65535, 7};
  int sc [2], fc [2];

  function automatic bit hitm(int m, int k, int r);
    return p[m][k].v && p[m][k].w && p[m][k].rd == r && r != 0;
  endfunction

  function automatic int efwd(int m, int r, bit u);
    if (!u) return 0;
    for (int k = 1; k < ns[m]; k++)
      if (hitm(m, k, r)) return (p[m][k].l && k < ns[m] - 1) ? 0 : k;
    return 0;
  endfunction

  // a source waits while its producer cannot yet deliver: loads until past the last
  // memory stage for EX users, any fresh writer or unfinished load for the branch comparator
  function automatic bit estall(int m);
    int r [2];
    bit u [2];
    if (hold) return 1;
    if (!dec_valid) return 0;
    r[0] = int'(dec_rs1); r[1] = int'(dec_rs2);
    u[0] = dec_rs1_used; u[1] = dec_rs2_used;
    for (int s = 0; s < ns[m]; s++)
      for (int j = 0; j < 2; j++)
        if (u[j] && hitm(m, s, r[j])) begin
          if (p[m][s].l && s <= ns[m] - 3) return 1;
          if (dec_is_branch && (s == 0 || (p[m][s].l && s <= ns[m] - 2))) return 1;
        end
    return 0;
  endfunction

  task automatic model_rst();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 8; k++) p[m][k] = '{default: 0};
      sc[m] = 0;
      fc[m] = 0;
    end
  endtask

  task automatic model_adv();
    for (int m = 0; m < 2; m++) begin
      bit st, fl;
      st = estall(m);
      fl = dec_valid && dec_is_branch && branch_taken && !st;
      if (reset) model_rst();
      else if (!hold) begin
        if (st && sc[m] < cmax[m]) sc[m]++;
        if (fl && fc[m] < cmax[m]) fc[m]++;
        for (int k = ns[m] - 1; k >= 1; k--) p[m][k] = p[m][k-1];
        p[m][0] = '{v: dec_valid && !st, w: dec_wre, l: dec_is_load, u1: dec_rs1_used, u2: dec_rs2_used,
                    rd: int'(dec_rd), rs1: int'(dec_rs1), rs2: int'(dec_rs2)};
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp(int m, logic st, logic bu, logic fl, logic [31:0] ea, logic [31:0] eb,
                     logic [31:0] da, logic [31:0] db, logic [31:0] scv, logic [31:0] fcv);
    bit es;
    es = estall(m);
    chk($sformatf("m%0d stall", m), 32'(st), 32'(es));
    chk($sformatf("m%0d bubble", m), 32'(bu), 32'(es && !hold));
    chk($sformatf("m%0d flush", m), 32'(fl), 32'(dec_valid && dec_is_branch && branch_taken && !es));
    chk($sformatf("m%0d fwd_ex_a", m), ea, efwd(m, p[m][0].rs1, p[m][0].v && p[m][0].u1));
    chk($sformatf("m%0d fwd_ex_b", m), eb, efwd(m, p[m][0].rs2, p[m][0].v && p[m][0].u2));
    chk($sformatf("m%0d fwd_dec_a", m), da, dec_is_branch ? efwd(m, int'(dec_rs1), dec_rs1_used) : 0);
    chk($sformatf("m%0d fwd_dec_b", m), db, dec_is_branch ? efwd(m, int'(dec_rs2), dec_rs2_used) : 0);
    chk($sformatf("m%0d stall_count", m), scv, sc[m]);
    chk($sformatf("m%0d flush_count", m), fcv, fc[m]);
  endtask

  task automatic cyc();
    cmp(0, s1, b1, f1, 32'(ea1), 32'(eb1), 32'(da1), 32'(db1), 32'(sc1), 32'(fc1));
    cmp(1, s3, b3, f3, 32'(ea3), 32'(eb3), 32'(da3), 32'(db3), 32'(sc3), 32'(fc3));
    model_adv();
    @(negedge clk);
  endtask

  task automatic drv(bit v, int r1, bit u1, int r2, bit u2, int rd, bit w, bit l, bit b, bit t);
    dec_valid = v; dec_rs1 = 4'(r1); dec_rs1_used = u1; dec_rs2 = 4'(r2); dec_rs2_used = u2;
    dec_rd = 4'(rd); dec_wre = w; dec_is_load = l; dec_is_branch = b; branch_taken = t;
    #1;
  endtask

  task automatic drain();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc();
  endtask

  initial begin
    reset = 1; hold = 0;
    model_rst();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc();
    reset = 0;
    #1;
    chk("rst stall", 32'(s1), 0);
    chk("rst fwd_ex_a", 32'(ea1), 0);
    chk("rst counts", 32'({sc1, fc1}), 0);
    // ALU -> ALU: no stall, youngest slot forwards
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc();
    drv(1, 3, 1, 0, 0, 6, 1, 0, 0, 0); chk("alu nostall", 32'(s1), 0); cyc();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); chk("alu fwd1", 32'(ea1), 1); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("alu fwd2", 32'(ea1), 2); cyc();
    // load -> use
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); cyc();
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0); chk("lu stall", 32'(s1), 1); chk("lu bubble", 32'(b1), 1); cyc();
    chk("lu release", 32'(s1), 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("lu fwd", 32'(ea1), 2); chk("lu count", 32'(sc1), 1); cyc();
    drain();
    // ALU -> taken branch
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); cyc();
    drv(1, 2, 1, 7, 1, 0, 0, 0, 1, 1); chk("br stall", 32'(s1), 1); chk("br noflush", 32'(f1), 0); cyc();
    chk("br release", 32'(s1), 0); chk("br fwd", 32'(da1), 1); chk("br flush", 32'(f1), 1); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("br fcount", 32'(fc1), 1); cyc();
    drain();
    // load -> branch
    drv(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); cyc();
    drv(1, 4, 1, 0, 0, 0, 0, 0, 1, 0); chk("lb stall1", 32'(s1), 1); cyc();
    chk("lb stall2", 32'(s1), 1); cyc();
    chk("lb release", 32'(s1), 0); chk("lb fwd", 32'(da1), 2); chk("lb noflush", 32'(f1), 0); cyc();
    drain();
    // hard-wired zero register
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); cyc();
    drv(1, 0, 1, 0, 1, 1, 1, 0, 0, 0); chk("r0 nostall", 32'(s1), 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("r0 fwd", 32'(ea1), 0); cyc();
    drain();
    // three-stage memory load-use
    drv(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); cyc();
    drv(1, 0, 0, 9, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin chk($sformatf("ml3 stall%0d", i), 32'(s3), 1); cyc(); end
    chk("ml3 release", 32'(s3), 0); cyc();
    drain();
    // global freeze
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); cyc();
    hold = 1; sav_s = sc1; sav_f = fc1;
    drv(1, 5, 1, 0, 0, 2, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold stall", 32'(s1), 1); chk("hold bubble", 32'(b1), 0);
      chk("hold counts", 32'({sc1, fc1}), 32'({sav_s, sav_f})); cyc();
    end
    hold = 0;
    drv(1, 5, 1, 0, 0, 2, 1, 0, 0, 0); chk("unhold stall", 32'(s1), 1); cyc();
    drain();
    // reset in the middle of a load-use stall
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); cyc();
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0); chk("pre-rst stall", 32'(s1), 1);
    reset = 1; #1;
    chk("mid-rst stall", 32'(s1), 0); chk("mid-rst counts", 32'({sc1, fc1}), 0);
    model_rst();
    cyc();
    reset = 0;
    drain();
    for (int i = 0; i < 600; i++) begin
      hold = ($urandom_range(0, 9) == 0);
      drv($urandom_range(0, 9) != 0, $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 5),
          $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1));
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard-and-forwarding controller for the pipelined core. It keeps a scoreboard of in-flight destination registers for Execute, a configurable number of Memory stages, and Writeback. From that scoreboard it drives:
- Execute-stage and Decode-stage (branch-compare) forwarding selects.
- Load-use and branch-operand stalls and Decode-Execute bubbles.
- Fetch-Decode flush on taken branches.
- Saturating stall and flush performance counters.

## Interface
Parameters:
- REG_ADDR_W, 4, register index width.
- MEM_LAT, 1, number of Memory stages (≥1); NSLOT = MEM_LAT+2 scoreboard slots (slot 0 = EX, 1..MEM_LAT = MEM, NSLOT-1 = WB).
- ZERO_REG_EN, 1, when 1 register index 0 never matches (hard-wired zero).
- CNT_W, 16, performance counter width.
- FWD_W = $clog2(NSLOT), derived, forward-select width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- hold  in  1  global freeze (e.g. memory wait); scoreboard and counters do not advance.
- dec_valid  in  1  Decode holds a real instruction.
- dec_rs1, dec_rs2  in  REG_ADDR_W  source indices of Decode instruction.
- dec_rs1_used, dec_rs2_used  in  1  source actually read.
- dec_rd  in  REG_ADDR_W  destination index.
- dec_wre  in  1  instruction writes the register file.
- dec_is_load  in  1  result comes from data memory.
- dec_is_branch  in  1  operands consumed by the Decode comparator.
- branch_taken  in  1  comparator result, meaningful only when dec_is_branch.
- stall  out  1  hold PC and Fetch-Decode register.
- bubble  out  1  load nop into Decode-Execute register.
- flush_fd  out  1  clear Fetch-Decode register to nop.
- fwd_ex_a, fwd_ex_b  out  FWD_W  EX operand source: 0 = pipeline register, k = slot k result.
- fwd_dec_a, fwd_dec_b  out  FWD_W  Decode comparator operand source, same encoding.
- stall_count, flush_count  out  CNT_W  saturating event counters.

## Operation
- Slot contents: valid, rd, wre, is_load. Slot 0 additionally holds rs1, rs2, rs1_used and rs2_used for EX forwarding.
- Match(slot, r) = valid & wre & rd==r & !(ZERO_REG_EN & r==0).
- EX forwarding:
  - For each used EX source, fwd_ex = smallest k in 1..NSLOT-1 with Match. This is the youngest writer.
  - Matching loads only qualify at k = NSLOT-1. If the youngest matching writer is a load below NSLOT-1, no forwarding is applied; the stall rules below make this unreachable.
  - The select is 0 if there is no match.
- Decode forwarding: same search over slots 1..NSLOT-1 with the same load restriction, applied only when dec_is_branch. The select is 0 otherwise.
- Load-use stall: dec_valid, a used source matches a load in slot s ≤ MEM_LAT-1.
- Branch stall: dec_valid & dec_is_branch, and a used source matches either of:
  - any writer in slot 0;
  - a load in slot s ≤ NSLOT-2.
- stall = hold | load-use stall | branch stall.
- bubble = stall & !hold.
- flush_fd = dec_valid & dec_is_branch & branch_taken & !stall.
- Advance (hold=0):
  - Slot k+1 ← slot k.
  - Slot 0 ← Decode info if dec_valid & !stall; otherwise an invalid slot.
  - Slot NSLOT-1 content is discarded.
- hold=1: all slots keep their contents.
- Counters (only when hold=0):
  - stall_count increments on cycles where bubble=1.
  - flush_count increments on cycles where flush_fd=1.
  - Both saturate at all-ones.

## Timing
- All outputs except the counters are combinational from slots and dec_* inputs in the same cycle. There are no internal bubbles and no added latency.
- Scoreboard and counters update on the rising clk edge.
- Reset, asynchronous:
  - all slots invalid;
  - counters 0;
  - with hold=0: stall=0, bubble=0, all fwd selects 0;
  - flush_fd follows inputs.
- A reset asserted mid-stall drops the stall immediately, because no valid slots remain.
- Stall length with MEM_LAT=1:
  - ALU→ALU: 0 cycles.
  - load→use: 1 cycle.
  - ALU→branch: 1 cycle.
  - load→branch: 2 cycles.
- When several slots match, the youngest wins.
- When both sources match, each is resolved independently.
- A branch that stalls is not flushed until the cycle its stall clears.

## Test plan
- ALU r3←; next instr reads rs1=r3 → no stall, fwd_ex_a=1. One cycle later a reader gets fwd_ex_a=2.
- load r5 then add reading r5 (MEM_LAT=1) → stall=bubble=1 for 1 cycle, then fwd_ex_a=2, stall_count=1.
- ALU r2← followed by taken beq on r2 → 1-cycle stall, then fwd_dec=1 and flush_fd=1 for one cycle, flush_count=1.
- load r4 then beq on r4 → stall for 2 cycles, then fwd_dec=2 and flush_fd as branch_taken.
- Writer to r0 with ZERO_REG_EN=1, reader of r0 → no stall, fwd=0. Repeat with MEM_LAT=3 load-use → 3 stall cycles.
- hold=1 for 5 cycles mid-sequence → slots frozen, counters unchanged. Assert reset during a load-use stall → stall=0 immediately, counters 0.
